// File: rtl/sum_xchg_link.sv
// Bidirectional partial-sum exchange link between core 0 and core 1 with exchange round counter.
// Optional macro SUM_XCHG_ERR_EN implements the sticky overflow/underflow flags and clr_err.

module sum_xchg_fifo #(
    parameter int W     = 24,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_vld,
    input  logic [W-1:0] push_data,
    input  logic         rd_req,
    output logic [W-1:0] sum_in,
    output logic         rd_vld,
    output logic         pop,
    output logic         ovf_evt,
    output logic         udf_evt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [W-1:0] sum_in_q, sum_in_d;
    logic         rd_vld_q, rd_vld_d;
    logic         full, empty, push;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees a slot at the same edge, so a push into a full FIFO is still taken.
    assign pop     = rd_req && !empty;
    assign push    = push_vld && (!full || pop);
    assign ovf_evt = push_vld && full && !pop;
    assign udf_evt = rd_req && empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        sum_in_d = sum_in_q;
        rd_vld_d = pop;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            sum_in_d = mem_q[rd_ptr_q[AW-1:0]];
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            sum_in_q <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            sum_in_q <= sum_in_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    // Storage needs no reset: reset empties the FIFO through the pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign sum_in = sum_in_q;
    assign rd_vld = rd_vld_q;
endmodule

module sum_xchg_link #(
    parameter int bw_psum = 20,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [bw_psum+3:0] c0_sum_out,
    input  logic               c0_sum_out_vld,
    input  logic               c0_fifo_ext_rd,
    output logic [bw_psum+3:0] c0_sum_in,
    output logic               c0_sum_rd_vld,
    input  logic [bw_psum+3:0] c1_sum_out,
    input  logic               c1_sum_out_vld,
    input  logic               c1_fifo_ext_rd,
    output logic [bw_psum+3:0] c1_sum_in,
    output logic               c1_sum_rd_vld,
    input  logic               clr_err,
    output logic [1:0]         link_ovf,
    output logic [1:0]         link_udf,
    output logic [7:0]         round_cnt
);
    localparam int W = bw_psum + 4;

    localparam logic [1:0] WAIT_BOTH = 2'd0;
    localparam logic [1:0] WAIT_C0   = 2'd1;
    localparam logic [1:0] WAIT_C1   = 2'd2;

    logic       dlv0, dlv1;
    logic [1:0] ovf_evt, udf_evt;

    // FIFO A carries core 0 sums to core 1.
    sum_xchg_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo_a (
        .clk(clk), .rst_n(reset),
        .push_vld(c0_sum_out_vld), .push_data(c0_sum_out),
        .rd_req(c1_fifo_ext_rd),
        .sum_in(c1_sum_in), .rd_vld(c1_sum_rd_vld), .pop(dlv1),
        .ovf_evt(ovf_evt[0]), .udf_evt(udf_evt[1])
    );

    sum_xchg_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo_b (
        .clk(clk), .rst_n(reset),
        .push_vld(c1_sum_out_vld), .push_data(c1_sum_out),
        .rd_req(c0_fifo_ext_rd),
        .sum_in(c0_sum_in), .rd_vld(c0_sum_rd_vld), .pop(dlv0),
        .ovf_evt(ovf_evt[1]), .udf_evt(udf_evt[0])
    );

    logic [1:0] state_q, state_d;
    logic [7:0] round_cnt_q, round_cnt_d;

    always_comb begin
        state_d     = state_q;
        round_cnt_d = round_cnt_q;
        case (state_q)
            WAIT_BOTH: begin
                if (dlv0 && dlv1) round_cnt_d = round_cnt_q + 8'd1;
                else if (dlv1)    state_d = WAIT_C0;
                else if (dlv0)    state_d = WAIT_C1;
            end
            WAIT_C0: begin
                if (dlv0) begin
                    round_cnt_d = round_cnt_q + 8'd1;
                    state_d     = WAIT_BOTH;
                end
            end
            WAIT_C1: begin
                if (dlv1) begin
                    round_cnt_d = round_cnt_q + 8'd1;
                    state_d     = WAIT_BOTH;
                end
            end
            default: state_d = WAIT_BOTH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= WAIT_BOTH;
            round_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            round_cnt_q <= round_cnt_d;
        end
    end

    assign round_cnt = round_cnt_q;

`ifdef SUM_XCHG_ERR_EN
    logic [1:0] link_ovf_q, link_ovf_d, link_udf_q, link_udf_d;

    // A fresh error in the clearing cycle keeps its flag set.
    always_comb begin
        link_ovf_d = (clr_err ? 2'b00 : link_ovf_q) | ovf_evt;
        link_udf_d = (clr_err ? 2'b00 : link_udf_q) | udf_evt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            link_ovf_q <= '0;
            link_udf_q <= '0;
        end else begin
            link_ovf_q <= link_ovf_d;
            link_udf_q <= link_udf_d;
        end
    end

    assign link_ovf = link_ovf_q;
    assign link_udf = link_udf_q;
`else
    logic unused_err;
    assign unused_err = ^{clr_err, ovf_evt, udf_evt};
    assign link_ovf   = 2'b00;
    assign link_udf   = 2'b00;
`endif
endmodule

// File: tb/tb_sum_xchg_link.sv
// Randomized + directed bench for sum_xchg_link against a queue-based reference model.
module tb_sum_xchg_link;
    localparam int W     = 24;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] c0_sum_out = '0, c1_sum_out = '0;
    logic         c0_sum_out_vld = 1'b0, c1_sum_out_vld = 1'b0;
    logic         c0_fifo_ext_rd = 1'b0, c1_fifo_ext_rd = 1'b0;
    logic         clr_err = 1'b0;
    logic [W-1:0] c0_sum_in, c1_sum_in;
    logic         c0_sum_rd_vld, c1_sum_rd_vld;
    logic [1:0]   link_ovf, link_udf;
    logic [7:0]   round_cnt;

    sum_xchg_link #(.bw_psum(W-4), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .c0_sum_out(c0_sum_out), .c0_sum_out_vld(c0_sum_out_vld),
        .c0_fifo_ext_rd(c0_fifo_ext_rd), .c0_sum_in(c0_sum_in), .c0_sum_rd_vld(c0_sum_rd_vld),
        .c1_sum_out(c1_sum_out), .c1_sum_out_vld(c1_sum_out_vld),
        .c1_fifo_ext_rd(c1_fifo_ext_rd), .c1_sum_in(c1_sum_in), .c1_sum_rd_vld(c1_sum_rd_vld),
        .clr_err(clr_err), .link_ovf(link_ovf), .link_udf(link_udf), .round_cnt(round_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one queue per direction, a pair of "delivered" flags per round.
    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    logic [W-1:0] m_c0_in, m_c1_in;
    logic         m_c0_vld, m_c1_vld;
    logic [1:0]   m_ovf, m_udf;
    logic [7:0]   m_cnt;
    logic         got0, got1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            qa.delete(); qb.delete();
            m_c0_in = '0; m_c1_in = '0; m_c0_vld = 0; m_c1_vld = 0;
            m_ovf = 0; m_udf = 0; m_cnt = 0; got0 = 0; got1 = 0;
        end else begin : model
            logic d0, d1;
            logic [1:0] oe, ue;
            d0 = c0_fifo_ext_rd && qb.size() > 0;
            d1 = c1_fifo_ext_rd && qa.size() > 0;
            oe = {c1_sum_out_vld && qb.size() == DEPTH && !d0,
                  c0_sum_out_vld && qa.size() == DEPTH && !d1};
            ue = {c1_fifo_ext_rd && qa.size() == 0, c0_fifo_ext_rd && qb.size() == 0};
            if (d0) m_c0_in = qb.pop_front();
            if (d1) m_c1_in = qa.pop_front();
            m_c0_vld = d0;
            m_c1_vld = d1;
            if (c0_sum_out_vld && qa.size() < DEPTH) qa.push_back(c0_sum_out);
            if (c1_sum_out_vld && qb.size() < DEPTH) qb.push_back(c1_sum_out);
`ifdef SUM_XCHG_ERR_EN
            if (clr_err) begin m_ovf = 0; m_udf = 0; end
            m_ovf |= oe;
            m_udf |= ue;
`endif
            got0 |= d0;
            got1 |= d1;
            if (got0 && got1) begin
                m_cnt += 8'd1;
                got0 = 0;
                got1 = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("c0_sum_in",     32'(c0_sum_in),     32'(m_c0_in));
        chk("c1_sum_in",     32'(c1_sum_in),     32'(m_c1_in));
        chk("c0_sum_rd_vld", 32'(c0_sum_rd_vld), 32'(m_c0_vld));
        chk("c1_sum_rd_vld", 32'(c1_sum_rd_vld), 32'(m_c1_vld));
        chk("link_ovf",      32'(link_ovf),      32'(m_ovf));
        chk("link_udf",      32'(link_udf),      32'(m_udf));
        chk("round_cnt",     32'(round_cnt),     32'(m_cnt));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        c0_sum_out_vld = 0; c1_sum_out_vld = 0;
        c0_fifo_ext_rd = 0; c1_fifo_ext_rd = 0; clr_err = 0;
    endtask

    logic [1:0] exp_udf_hi, exp_ovf_lo;

    initial begin
`ifdef SUM_XCHG_ERR_EN
        exp_udf_hi = 2'b10; exp_ovf_lo = 2'b01;
`else
        exp_udf_hi = 2'b00; exp_ovf_lo = 2'b00;
`endif
        #12;
        chk("reset_c0_in", 32'(c0_sum_in), 0);
        chk("reset_cnt", 32'(round_cnt), 0);
        reset = 1;
        step();

        // core 0 -> core 1 then core 1 -> core 0: one full round
        c0_sum_out = 24'h000123; c0_sum_out_vld = 1; step();
        idle(); c1_fifo_ext_rd = 1; step();
        chk("s1_c1_in", 32'(c1_sum_in), 32'h123);
        chk("s1_c1_vld", 32'(c1_sum_rd_vld), 1);
        chk("s1_cnt", 32'(round_cnt), 0);
        idle(); step();
        chk("s1_c1_vld_drop", 32'(c1_sum_rd_vld), 0);
        c1_sum_out = 24'h000456; c1_sum_out_vld = 1; step();
        idle(); c0_fifo_ext_rd = 1; step();
        chk("s2_c0_in", 32'(c0_sum_in), 32'h456);
        chk("s2_c0_vld", 32'(c0_sum_rd_vld), 1);
        chk("s2_cnt", 32'(round_cnt), 1);
        idle();

        // overflow then drain with underflow
        for (int i = 1; i <= 5; i++) begin
            c0_sum_out = 24'(i); c0_sum_out_vld = 1; step();
        end
        idle(); step();
        chk("s3_ovf", 32'(link_ovf), 32'(exp_ovf_lo));
        for (int i = 1; i <= 4; i++) begin
            c1_fifo_ext_rd = 1; step();
            chk("s3_rd_data", 32'(c1_sum_in), 32'(i));
            chk("s3_rd_vld", 32'(c1_sum_rd_vld), 1);
        end
        step();
        chk("s3_udf_vld", 32'(c1_sum_rd_vld), 0);
        chk("s3_udf_hold", 32'(c1_sum_in), 4);
        chk("s3_udf", 32'(link_udf), 32'(exp_udf_hi));
        idle(); clr_err = 1; step();
        chk("clr_ovf", 32'(link_ovf), 0);
        chk("clr_udf", 32'(link_udf), 0);
        idle();

        // push into a full FIFO while it is popped
        for (int i = 0; i < 4; i++) begin
            c0_sum_out = 24'(8'h10 + i); c0_sum_out_vld = 1; step();
        end
        c0_sum_out = 24'h0000AA; c1_fifo_ext_rd = 1; step();
        chk("s4_oldest", 32'(c1_sum_in), 32'h10);
        chk("s4_no_ovf", 32'(link_ovf), 0);
        c0_sum_out_vld = 0;
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("s4_drain", 32'(c1_sum_in), (i == 4) ? 32'hAA : 32'(8'h10 + i));
        end
        idle(); step();

        // 256 simultaneous rounds from a clean state
        reset = 0; #2; reset = 1; step();
        for (int r = 0; r < 256; r++) begin
            c0_sum_out = 24'($urandom); c1_sum_out = 24'($urandom);
            c0_sum_out_vld = 1; c1_sum_out_vld = 1; step();
            idle(); c0_fifo_ext_rd = 1; c1_fifo_ext_rd = 1; step();
            if (r == 0) begin
                chk("s5_both_vld", 32'({c0_sum_rd_vld, c1_sum_rd_vld}), 3);
                chk("s5_cnt1", 32'(round_cnt), 1);
            end
            idle();
        end
        chk("s5_wrap", 32'(round_cnt), 0);

        // reset with buffered words
        for (int i = 0; i < 3; i++) begin
            c0_sum_out = 24'(i + 7); c0_sum_out_vld = 1; step();
        end
        idle(); c1_fifo_ext_rd = 1; step();
        idle();
        reset = 0; #1;
        chk("s6_rst_in", 32'({c0_sum_in, c1_sum_in}), 0);
        chk("s6_rst_vld", 32'({c0_sum_rd_vld, c1_sum_rd_vld}), 0);
        chk("s6_rst_flags", 32'({link_ovf, link_udf, round_cnt}), 0);
        #2; reset = 1; step();
        c1_fifo_ext_rd = 1; step();
        chk("s6_rd_vld", 32'(c1_sum_rd_vld), 0);
        chk("s6_udf", 32'(link_udf), 32'(exp_udf_hi));
        idle();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            c0_sum_out = 24'($urandom); c1_sum_out = 24'($urandom);
            c0_sum_out_vld = 1'($urandom_range(0, 1));
            c1_sum_out_vld = 1'($urandom_range(0, 1));
            c0_fifo_ext_rd = 1'($urandom_range(0, 1));
            c1_fifo_ext_rd = 1'($urandom_range(0, 1));
            clr_err = ($urandom_range(0, 15) == 0);
            step();
        end
        idle();
        step();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
